// File: rtl/bimodal_update_scheduler.sv
// -----------------------------------------------------------------------------
// bimodal_update_scheduler
//
// Purpose:
//   Arbitrates the single index port of the bimodal counter table between
//   fetch-side lookups and commit-side counter updates. Lookups win by
//   default. Updates wait in a small FIFO and drain in three cases: when no
//   lookup is requested, when the FIFO is full, or when the FIFO has been
//   denied for SL-1 consecutive cycles.
//
// Parameters:
//   IL - index width (table holds 2^IL counters)
//   CL - counter width
//   QD - update FIFO depth (power of two, >= 2)
//   SL - starvation limit in cycles before a queued update is forced
//
// Ports:
//   Clk, Rst                  clock, synchronous active-high reset
//   lkp_valid/index/ready     lookup request handshake
//   rsp_valid/ctr/taken       lookup response, one cycle after acceptance
//   upd_valid/index/taken     update request (taken=1 increments)
//   upd_ready                 update is enqueued when valid && ready
//   tbl_index/rd/inc/dec/upd_en  table control outputs
//   tbl_rdata                 registered table read data
//   q_count                   FIFO occupancy
//   rsp_stale                 lookup hit a still-pending update
//                             (only with BIMODAL_SCHED_STALE_EN)
//
// Configuration macro:
//   BIMODAL_SCHED_STALE_EN - adds the rsp_stale port and the FIFO compare
// -----------------------------------------------------------------------------
module bimodal_update_scheduler #(
    parameter int IL = 13,
    parameter int CL = 3,
    parameter int QD = 4,
    parameter int SL = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  lkp_valid,
    input  logic [IL-1:0]         lkp_index,
    output logic                  lkp_ready,
    output logic                  rsp_valid,
    output logic [CL-1:0]         rsp_ctr,
    output logic                  rsp_taken,
    input  logic                  upd_valid,
    input  logic [IL-1:0]         upd_index,
    input  logic                  upd_taken,
    output logic                  upd_ready,
    output logic [IL-1:0]         tbl_index,
    output logic                  tbl_rd,
    output logic                  tbl_inc,
    output logic                  tbl_dec,
    output logic                  tbl_upd_en,
    input  logic [CL-1:0]         tbl_rdata,
    output logic [$clog2(QD):0]   q_count
`ifdef BIMODAL_SCHED_STALE_EN
    ,
    output logic                  rsp_stale
`endif
);

    localparam int PW = $clog2(QD);
    localparam int SW = (SL > 1) ? $clog2(SL) : 1;
    localparam logic [PW:0]   C_FULL       = (PW+1)'(QD);
    localparam logic [SW-1:0] C_STARVE_MAX = SW'(SL - 1);

    typedef enum logic [1:0] {
        GRANT_IDLE,
        GRANT_LKP,
        GRANT_UPD
    } grant_t;

    // FIFO storage and bookkeeping
    logic [IL-1:0] r_qIndex [QD];
    logic          r_qTaken [QD];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic [SW-1:0] r_starve;
    logic          r_rspValid;

    logic   w_empty;
    logic   w_flush;
    logic   w_enq;
    logic   w_deq;
    grant_t w_grant;

    // Grant decision. A flush (full FIFO or starvation limit) steals the
    // port from lookups; otherwise updates only use cycles lookups leave free.
    // Reset forces IDLE so no table control toggles while Rst is high.
    always_comb begin
        w_empty = (r_count == '0);
        w_flush = !w_empty && ((r_count == C_FULL) || (r_starve == C_STARVE_MAX));
        w_grant = GRANT_IDLE;
        if (!Rst) begin
            if (!w_empty && (w_flush || !lkp_valid)) begin
                w_grant = GRANT_UPD;
            end else if (lkp_valid && !w_flush) begin
                w_grant = GRANT_LKP;
            end
        end
    end

    // Table controls and handshakes derived from the grant
    always_comb begin
        tbl_index  = '0;
        tbl_rd     = 1'b0;
        tbl_inc    = 1'b0;
        tbl_dec    = 1'b0;
        tbl_upd_en = 1'b0;
        case (w_grant)
            GRANT_UPD: begin
                tbl_index  = r_qIndex[r_head];
                tbl_upd_en = 1'b1;
                tbl_inc    = r_qTaken[r_head];
                tbl_dec    = !r_qTaken[r_head];
            end
            GRANT_LKP: begin
                tbl_index = lkp_index;
                tbl_rd    = 1'b1;
            end
            default: begin
            end
        endcase
        lkp_ready = !Rst && !w_flush;
        upd_ready = !Rst && (r_count < C_FULL);
        w_enq     = upd_valid && upd_ready;
        w_deq     = (w_grant == GRANT_UPD);
    end

    // FIFO payload has no reset: validity is carried by head/count alone.
    always_ff @(posedge Clk) begin
        if (w_enq) begin
            r_qIndex[r_tail] <= upd_index;
            r_qTaken[r_tail] <= upd_taken;
        end
    end

    // Pointers wrap naturally because QD is a power of two. A new entry only
    // becomes visible at the edge, so it can never issue in its enqueue cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_starve   <= '0;
            r_rspValid <= 1'b0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
            // Starvation only accumulates while queued work loses to lookups
            if (w_empty || (w_grant == GRANT_UPD)) begin
                r_starve <= '0;
            end else if ((w_grant == GRANT_LKP) && (r_starve != C_STARVE_MAX)) begin
                r_starve <= r_starve + SW'(1);
            end
            r_rspValid <= (w_grant == GRANT_LKP);
        end
    end

    assign rsp_valid = r_rspValid;
    assign rsp_ctr   = tbl_rdata;
    assign rsp_taken = tbl_rdata[CL-1];
    assign q_count   = r_count;

`ifdef BIMODAL_SCHED_STALE_EN
    logic w_staleHit;
    logic r_stale;

    // An entry is pending when its distance from head is below count; the
    // head being dequeued this cycle no longer counts as pending.
    always_comb begin
        logic [PW-1:0] offset;
        w_staleHit = 1'b0;
        offset     = '0;
        for (int i = 0; i < QD; i++) begin
            offset = PW'(i) - r_head;
            if (({1'b0, offset} < r_count) &&
                !(w_deq && (PW'(i) == r_head)) &&
                (r_qIndex[i] == lkp_index)) begin
                w_staleHit = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_stale <= 1'b0;
        end else begin
            r_stale <= (w_grant == GRANT_LKP) && w_staleHit;
        end
    end

    assign rsp_stale = r_stale;
`endif

endmodule

// File: tb/tb_bimodal_update_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bimodal_update_scheduler
//
// Drives bimodal_update_scheduler against a behavioural counter table and a
// queue-based reference model of the scheduling rules. Directed vectors,
// hand-written corner sequences and a random phase all run through the same
// per-cycle model check.
// -----------------------------------------------------------------------------
module tb_bimodal_update_scheduler;

    localparam int IL  = 13;
    localparam int CL  = 3;
    localparam int QD  = 4;
    localparam int SL  = 8;
    localparam int TBL = 1 << IL;
    localparam int CMAX = (1 << CL) - 1;

    logic                 Clk;
    logic                 Rst;
    logic                 lkp_valid;
    logic [IL-1:0]        lkp_index;
    logic                 lkp_ready;
    logic                 rsp_valid;
    logic [CL-1:0]        rsp_ctr;
    logic                 rsp_taken;
    logic                 upd_valid;
    logic [IL-1:0]        upd_index;
    logic                 upd_taken;
    logic                 upd_ready;
    logic [IL-1:0]        tbl_index;
    logic                 tbl_rd;
    logic                 tbl_inc;
    logic                 tbl_dec;
    logic                 tbl_upd_en;
    logic [CL-1:0]        tbl_rdata;
    logic [$clog2(QD):0]  q_count;
`ifdef BIMODAL_SCHED_STALE_EN
    logic                 rsp_stale;
`endif

    bimodal_update_scheduler #(
        .IL(IL), .CL(CL), .QD(QD), .SL(SL)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .lkp_valid  (lkp_valid),
        .lkp_index  (lkp_index),
        .lkp_ready  (lkp_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ctr    (rsp_ctr),
        .rsp_taken  (rsp_taken),
        .upd_valid  (upd_valid),
        .upd_index  (upd_index),
        .upd_taken  (upd_taken),
        .upd_ready  (upd_ready),
        .tbl_index  (tbl_index),
        .tbl_rd     (tbl_rd),
        .tbl_inc    (tbl_inc),
        .tbl_dec    (tbl_dec),
        .tbl_upd_en (tbl_upd_en),
        .tbl_rdata  (tbl_rdata),
        .q_count    (q_count)
`ifdef BIMODAL_SCHED_STALE_EN
        ,
        .rsp_stale  (rsp_stale)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    function automatic int initVal(int i);
        if (i == 5 || i == 7 || i == 9 || i == 10) return 3;
        return i % 8;
    endfunction

    // Behavioural counter table driven by the DUT: saturating counters and
    // registered read data with one cycle of latency.
    logic [CL-1:0] tblMem [TBL];
    logic          tblInit;

    always @(posedge Clk) begin
        if (tblInit) begin
            for (int i = 0; i < TBL; i++) tblMem[i] <= CL'(initVal(i));
            tbl_rdata <= '0;
        end else begin
            if (tbl_upd_en === 1'b1) begin
                if (tbl_inc === 1'b1 && tblMem[tbl_index] != CL'(CMAX))
                    tblMem[tbl_index] <= tblMem[tbl_index] + CL'(1);
                if (tbl_dec === 1'b1 && tblMem[tbl_index] != '0)
                    tblMem[tbl_index] <= tblMem[tbl_index] - CL'(1);
            end
            if (tbl_rd === 1'b1) tbl_rdata <= tblMem[tbl_index];
        end
    end

    // Reference model state: pending updates as a plain queue, expected
    // table contents, starvation age and the expected response.
    typedef struct packed {
        logic [IL-1:0] idx;
        logic          taken;
    } ent_t;

    ent_t mq[$];
    int   mTbl [TBL];
    int   mStarve;
    bit   mRspValid;
    int   mRspCtr;
`ifdef BIMODAL_SCHED_STALE_EN
    bit   mStale;
`endif

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endfunction

    // One clock cycle: drive inputs after the falling edge, compare every
    // output with the model just before the rising edge, then advance the model.
    task automatic applyStimulus(input bit rst, input bit lv, input logic [IL-1:0] li,
                                 input bit uv, input logic [IL-1:0] ui, input bit ut);
        int            oldSize;
        bit            nonEmpty, flush, gUpd, gLkp, hit;
        logic [IL-1:0] eIdx;
        ent_t          e;
        @(negedge Clk);
        Rst       = rst;
        lkp_valid = lv;
        lkp_index = li;
        upd_valid = uv;
        upd_index = ui;
        upd_taken = ut;
        #1;
        oldSize  = mq.size();
        nonEmpty = (oldSize != 0);
        flush    = nonEmpty && (oldSize == QD || mStarve == SL - 1);
        gUpd     = !rst && nonEmpty && (flush || !lv);
        gLkp     = !rst && lv && !flush;
        eIdx     = '0;
        if (gUpd) eIdx = mq[0].idx;
        else if (gLkp) eIdx = li;

        checkOutput("lkp_ready", 32'(lkp_ready), 32'(!rst && !flush));
        checkOutput("upd_ready", 32'(upd_ready), 32'(!rst && oldSize < QD));
        checkOutput("tbl_rd", 32'(tbl_rd), 32'(gLkp));
        checkOutput("tbl_upd_en", 32'(tbl_upd_en), 32'(gUpd));
        checkOutput("tbl_inc", 32'(tbl_inc), 32'(gUpd && mq[0].taken));
        checkOutput("tbl_dec", 32'(tbl_dec), 32'(gUpd && !mq[0].taken));
        checkOutput("tbl_index", 32'(tbl_index), 32'(eIdx));
        checkOutput("q_count", 32'(q_count), 32'(oldSize));
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(mRspValid));
        if (mRspValid) begin
            checkOutput("rsp_ctr", 32'(rsp_ctr), 32'(mRspCtr));
            checkOutput("rsp_taken", 32'(rsp_taken), 32'((mRspCtr >> (CL - 1)) & 1));
        end
`ifdef BIMODAL_SCHED_STALE_EN
        checkOutput("rsp_stale", 32'(rsp_stale), 32'(mStale));
`endif

        if (rst) begin
            mq.delete();
            mStarve   = 0;
            mRspValid = 1'b0;
`ifdef BIMODAL_SCHED_STALE_EN
            mStale    = 1'b0;
`endif
        end else begin
            hit = 1'b0;
            foreach (mq[k]) if (mq[k].idx == li) hit = 1'b1;
            if (gLkp) mRspCtr = mTbl[int'(li)];
            mRspValid = gLkp;
`ifdef BIMODAL_SCHED_STALE_EN
            mStale = gLkp && hit;
`endif
            if (!nonEmpty || gUpd) mStarve = 0;
            else if (gLkp && mStarve < SL - 1) mStarve++;
            if (gUpd) begin
                e = mq.pop_front();
                if (e.taken && mTbl[int'(e.idx)] < CMAX) mTbl[int'(e.idx)]++;
                if (!e.taken && mTbl[int'(e.idx)] > 0) mTbl[int'(e.idx)]--;
            end
            if (uv && oldSize < QD) mq.push_back('{idx: ui, taken: ut});
        end
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, '0, 0, '0, 0);
    endtask

    // Directed vectors with hand-derived expectations.
    // grant: 0 idle, 1 lookup, 2 update increment, 3 update decrement
    typedef struct {
        bit rst;
        bit lv;
        int li;
        bit uv;
        int ui;
        bit ut;
        bit eLkpRdy;
        bit eUpdRdy;
        int eGrant;
        int eIdx;
        int eQ;
        bit eRspV;
        int eRspCtr;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int firstUpd;
        int lowCount;
        int updSeen;

        vecs[0]  = '{1, 1,  5, 1,  7, 1,  0, 0, 0,  0, 0, 0, 0};
        vecs[1]  = '{0, 1,  5, 0,  0, 0,  1, 1, 1,  5, 0, 0, 0};
        vecs[2]  = '{0, 0,  0, 1,  7, 1,  1, 1, 0,  0, 0, 1, 3};
        vecs[3]  = '{0, 0,  0, 1,  7, 1,  1, 1, 2,  7, 1, 0, 0};
        vecs[4]  = '{0, 0,  0, 0,  0, 0,  1, 1, 2,  7, 1, 0, 0};
        vecs[5]  = '{0, 1,  7, 0,  0, 0,  1, 1, 1,  7, 0, 0, 0};
        vecs[6]  = '{0, 0,  0, 0,  0, 0,  1, 1, 0,  0, 0, 1, 5};
        vecs[7]  = '{0, 1, 20, 1, 30, 0,  1, 1, 1, 20, 0, 0, 0};
        vecs[8]  = '{0, 1, 21, 1, 31, 0,  1, 1, 1, 21, 1, 1, 4};
        vecs[9]  = '{0, 1, 22, 1, 32, 0,  1, 1, 1, 22, 2, 1, 5};
        vecs[10] = '{0, 1, 23, 1, 33, 0,  1, 1, 1, 23, 3, 1, 6};
        vecs[11] = '{0, 1, 24, 0,  0, 0,  0, 0, 3, 30, 4, 1, 7};
        vecs[12] = '{0, 1, 24, 0,  0, 0,  1, 1, 1, 24, 3, 0, 0};

        Rst       = 1'b1;
        lkp_valid = 1'b0;
        lkp_index = '0;
        upd_valid = 1'b0;
        upd_index = '0;
        upd_taken = 1'b0;
        tblInit   = 1'b1;
        for (int i = 0; i < TBL; i++) mTbl[i] = initVal(i);
        mStarve   = 0;
        mRspValid = 1'b0;
        mRspCtr   = 0;
`ifdef BIMODAL_SCHED_STALE_EN
        mStale    = 1'b0;
`endif
        repeat (2) @(posedge Clk);
        #1;
        tblInit = 1'b0;

        $display("[TB] directed vectors");
        for (int v = 0; v < 13; v++) begin
            applyStimulus(vecs[v].rst, vecs[v].lv, IL'(vecs[v].li),
                          vecs[v].uv, IL'(vecs[v].ui), vecs[v].ut);
            checkOutput($sformatf("vec%0d lkp_ready", v), 32'(lkp_ready), 32'(vecs[v].eLkpRdy));
            checkOutput($sformatf("vec%0d upd_ready", v), 32'(upd_ready), 32'(vecs[v].eUpdRdy));
            checkOutput($sformatf("vec%0d tbl_rd", v), 32'(tbl_rd), 32'(vecs[v].eGrant == 1));
            checkOutput($sformatf("vec%0d tbl_upd_en", v), 32'(tbl_upd_en), 32'(vecs[v].eGrant >= 2));
            checkOutput($sformatf("vec%0d tbl_inc", v), 32'(tbl_inc), 32'(vecs[v].eGrant == 2));
            checkOutput($sformatf("vec%0d tbl_dec", v), 32'(tbl_dec), 32'(vecs[v].eGrant == 3));
            checkOutput($sformatf("vec%0d tbl_index", v), 32'(tbl_index), 32'(vecs[v].eIdx));
            checkOutput($sformatf("vec%0d q_count", v), 32'(q_count), 32'(vecs[v].eQ));
            checkOutput($sformatf("vec%0d rsp_valid", v), 32'(rsp_valid), 32'(vecs[v].eRspV));
            if (vecs[v].eRspV) begin
                checkOutput($sformatf("vec%0d rsp_ctr", v), 32'(rsp_ctr), 32'(vecs[v].eRspCtr));
                checkOutput($sformatf("vec%0d rsp_taken", v), 32'(rsp_taken),
                            32'((vecs[v].eRspCtr >> (CL - 1)) & 1));
            end
        end
        idleCycles(4);

        $display("[TB] starvation with one queued update");
        applyStimulus(0, 1, IL'(40), 1, IL'(41), 1);
        firstUpd = -1;
        lowCount = 0;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(0, 1, IL'(40 + k), 0, '0, 0);
            if (tbl_upd_en === 1'b1 && firstUpd < 0) begin
                firstUpd = k;
                checkOutput("starve tbl_index", 32'(tbl_index), 32'(41));
            end
            if (lkp_ready !== 1'b1) lowCount++;
        end
        checkOutput("starve issue cycle", 32'(firstUpd), 32'(SL));
        checkOutput("starve stall cycles", 32'(lowCount), 32'(1));
        idleCycles(2);

        $display("[TB] simultaneous enqueue and dequeue");
        applyStimulus(0, 1, IL'(60), 1, IL'(61), 1);
        applyStimulus(0, 1, IL'(62), 1, IL'(63), 0);
        applyStimulus(0, 0, '0, 1, IL'(64), 1);
        checkOutput("encdeq q_count before", 32'(q_count), 32'(2));
        checkOutput("encdeq first index", 32'(tbl_index), 32'(61));
        applyStimulus(0, 0, '0, 0, '0, 0);
        checkOutput("encdeq q_count after", 32'(q_count), 32'(2));
        checkOutput("encdeq second index", 32'(tbl_index), 32'(63));
        checkOutput("encdeq second dec", 32'(tbl_dec), 32'(1));
        applyStimulus(0, 0, '0, 0, '0, 0);
        checkOutput("encdeq third index", 32'(tbl_index), 32'(64));
        idleCycles(2);

        $display("[TB] reset with queued updates");
        applyStimulus(0, 1, IL'(80), 1, IL'(70), 1);
        applyStimulus(0, 1, IL'(81), 1, IL'(71), 0);
        applyStimulus(0, 1, IL'(82), 1, IL'(72), 1);
        applyStimulus(1, 1, IL'(83), 1, IL'(73), 1);
        checkOutput("rst lkp_ready", 32'(lkp_ready), 32'(0));
        checkOutput("rst upd_ready", 32'(upd_ready), 32'(0));
        checkOutput("rst tbl_upd_en", 32'(tbl_upd_en), 32'(0));
        checkOutput("rst tbl_rd", 32'(tbl_rd), 32'(0));
        applyStimulus(0, 0, '0, 0, '0, 0);
        checkOutput("post-rst q_count", 32'(q_count), 32'(0));
        checkOutput("post-rst rsp_valid", 32'(rsp_valid), 32'(0));
        updSeen = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, '0, 0, '0, 0);
            if (tbl_upd_en !== 1'b0) updSeen++;
        end
        checkOutput("post-rst updates", 32'(updSeen), 32'(0));

`ifdef BIMODAL_SCHED_STALE_EN
        $display("[TB] stale response detection");
        applyStimulus(0, 1, IL'(50), 1, IL'(9), 1);
        applyStimulus(0, 1, IL'(9), 0, '0, 0);
        applyStimulus(0, 1, IL'(10), 0, '0, 0);
        checkOutput("stale hit valid", 32'(rsp_valid), 32'(1));
        checkOutput("stale hit", 32'(rsp_stale), 32'(1));
        applyStimulus(0, 0, '0, 0, '0, 0);
        checkOutput("stale miss valid", 32'(rsp_valid), 32'(1));
        checkOutput("stale miss", 32'(rsp_stale), 32'(0));
        idleCycles(2);
`endif

        $display("[TB] randomized traffic");
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(99) == 0,
                          $urandom_range(9) < 7,
                          IL'($urandom_range(15)),
                          $urandom_range(1) == 1,
                          IL'($urandom_range(15)),
                          $urandom_range(1) == 1);
        end
        idleCycles(QD + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/bimodal_update_scheduler.md
# bimodal_update_scheduler

Shares the single index port of the bimodal counter table between fetch-side lookups and commit-side counter updates. Lookups have priority; updates are buffered in a small FIFO and drained in idle cycles, when the FIFO is full, or when the starvation limit is reached. The block sits between the predictor front end and the bimodal table. It drives the table's index, read, increment/decrement and update-enable inputs, and returns the table's registered read data as the lookup response.

## Interface
Parameters:
- IL, 13, index width (table has 2^IL entries)
- CL, 3, counter width
- QD, 4, update FIFO depth (power of 2, ≥2)
- SL, 8, starvation limit: consecutive cycles a non-empty FIFO may be denied before an update is forced

Ports:
- Clk  in  1  clock; all state on posedge Clk
- Rst  in  1  synchronous, active-high reset
- lkp_valid  in  1  lookup request
- lkp_index  in  IL  lookup index
- lkp_ready  out  1  lookup accepted this cycle when lkp_valid && lkp_ready
- rsp_valid  out  1  lookup response valid
- rsp_ctr  out  CL  counter value for the response (tbl_rdata)
- rsp_taken  out  1  rsp_ctr[CL-1]
- upd_valid  in  1  update request
- upd_index  in  IL  index to update
- upd_taken  in  1  resolved direction: 1 = increment, 0 = decrement
- upd_ready  out  1  update enqueued when upd_valid && upd_ready
- tbl_index  out  IL  table index
- tbl_rd  out  1  table read enable
- tbl_inc  out  1  table increment
- tbl_dec  out  1  table decrement
- tbl_upd_en  out  1  table update enable
- tbl_rdata  in  CL  table registered read data (one-cycle latency)
- q_count  out  clog2(QD)+1  FIFO occupancy
- rsp_stale  out  1  present only with BIMODAL_SCHED_STALE_EN

## Operation
- FIFO entries hold {index, taken}. It uses head/tail pointers that wrap modulo QD, plus a count.
- Flush condition: FIFO non-empty AND (count == QD OR starve == SL-1).
- lkp_ready = !Rst && !flush. lkp_ready does not depend on lkp_valid.
- Grant per cycle:
  - UPD: the FIFO is non-empty and either flush is true or lkp_valid is low.
  - LKP: lkp_valid is high and flush is false.
  - IDLE: otherwise.
- On a UPD grant:
  - tbl_index = head index.
  - tbl_upd_en = 1, tbl_inc = taken, tbl_dec = !taken, tbl_rd = 0.
  - The head is dequeued.
  - Counter saturation is handled by the table.
- On an LKP grant: tbl_index = lkp_index, tbl_rd = 1, tbl_inc = tbl_dec = tbl_upd_en = 0.
- On IDLE: all table controls are 0 and tbl_index = 0.
- upd_ready = !Rst && (count < QD). Same-cycle enqueue of a new entry and dequeue of the head is allowed; count is then unchanged. An enqueued entry is never issued in the cycle it is enqueued.
- starve:
  - Increments when the FIFO is non-empty and the grant is LKP.
  - Clears on any UPD grant and whenever the FIFO is empty.
  - Saturates at SL-1.
- Updates issue in FIFO order. Each FIFO entry produces exactly one table update.

## Timing
- Reset values:
  - count = 0, head = tail = 0, starve = 0.
  - rsp_valid = 0, rsp_stale = 0.
  - lkp_ready = upd_ready = 0 while Rst is high.
  - All tbl_* controls = 0 while Rst is high.
- Lookup accepted at edge t → rsp_valid = 1 during cycle t+1, with rsp_ctr = tbl_rdata. rsp_valid is a registered copy of the LKP grant.
- An update granted at edge t writes the table at edge t. A lookup of the same index granted at edge t+1 or later sees the new value.
- Worst-case lookup stall is 1 cycle per forced update. With a full FIFO and continuous lookups, the pattern is one UPD cycle, then LKP cycles until the next flush.
- Rst asserted mid-operation: queued updates are discarded, and rsp_valid = 0 in the cycle after the reset edge. An in-flight response is dropped.

## Configuration
- BIMODAL_SCHED_STALE_EN defined:
  - On each LKP grant, lkp_index is compared against every valid FIFO entry. An entry being dequeued in the same cycle counts as no longer pending.
  - The registered OR of those comparisons drives rsp_stale, aligned with rsp_valid.
  - rsp_stale is 0 whenever rsp_valid is 0.
- Not defined: the rsp_stale port and all comparison logic are absent. All other behaviour is identical.

## Test plan
- Reset, then lookup of index 5 with a table counter of 3 → rsp_valid the next cycle, rsp_ctr = 3, rsp_taken = 0. With Rst high, all ready outputs and table controls are 0.
- Enqueue 2 updates (idx 7 taken, idx 7 taken), lkp_valid low → 2 consecutive UPD cycles with tbl_inc = 1 and tbl_index = 7. A later lookup of 7 from counter 3 returns 5.
- Continuous lkp_valid with 4 updates enqueued → the FIFO fills, lkp_ready drops for exactly 1 cycle per forced update, and q_count is 4 → 3.
- Continuous lkp_valid with 1 queued update, SL = 8 → the update issues on the 8th cycle after enqueue. lkp_ready is low for that cycle only.
- Simultaneous enqueue and dequeue at count = 2 → count stays 2 and FIFO order is preserved. Rst mid-queue → q_count = 0 and no table update issues afterwards.
- With STALE_EN: queue idx 9, lookup idx 9 while it is still queued → rsp_stale = 1. Lookup idx 10 → rsp_stale = 0.
